// File: rtl/seq_detect.sv
// Serial N-bit pattern detector with overlapping/non-overlapping modes; optional match counter (SEQDET_COUNT_EN).
// Latency: Z rises on the clock edge that accepts the completing bit and lasts one cycle per match.
// Backpressure: none; en qualifies each input bit, and history/fill hold while en=0.
module seq_detect #(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b1011,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             W,
    input  logic             overlap,
`ifdef SEQDET_COUNT_EN
    input  logic             count_clr,
    output logic [CNT_W-1:0] match_count,
`endif
    output logic             Z
);

    // Parameter legality: the shift window needs at least two bits, and the counter needs at least one.
    if (N < 2 || N > 16) begin : g_bad_n
        $error("seq_detect: N must be in 2..16");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("seq_detect: CNT_W must be at least 1");
    end

    localparam int            FW       = $clog2(N + 1);
    localparam logic [FW:0]   N_EXT    = (FW + 1)'(N);
    localparam logic [FW-1:0] FILL_MAX = FW'(N);
    localparam logic [FW-1:0] FILL_ONE = FW'(1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ARMED = 2'd1,
        HIT   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [FW-1:0]   fill;
    logic [FW-1:0]   fill_nxt;
    // Only the N-1 most recent bits are kept: the oldest bit of the window
    // leaves on the same shift that the new bit enters, so it is never read.
    logic [N-2:0]    hist;
    logic [N-1:0]    window;
    logic [FW:0]     fill_inc;
    logic            match;
    // Overlap mode captured on the edge that entered HIT; decides how HIT exits.
    logic            hit_ovl;

    assign window   = {hist, W};
    assign fill_inc = {1'b0, fill} + (FW + 1)'(1);
    // Fill gating keeps bits from before reset or a non-overlap clear from matching.
    assign match    = en && (fill_inc >= N_EXT) && (window == PATTERN);

    // State, fill counter, history and captured overlap mode.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= FILL;
            fill    <= '0;
            hist    <= '0;
            hit_ovl <= 1'b0;
        end else begin
            state <= state_nxt;
            fill  <= fill_nxt;
            if (en) begin
                hist <= window[N-2:0];
            end
            if (match) begin
                hit_ovl <= overlap;
            end
        end
    end

    // Next state and next fill; a match always wins and enters HIT.
    always_comb begin
        state_nxt = state;
        fill_nxt  = fill;
        case (state)
            FILL: begin
                if (en) begin
                    fill_nxt = fill_inc[FW-1:0];
                    if (fill_inc == N_EXT) begin
                        state_nxt = ARMED;
                    end
                end
            end
            ARMED: begin
                state_nxt = ARMED;
            end
            HIT: begin
                if (hit_ovl) begin
                    state_nxt = ARMED;
                end else begin
                    // Fill was cleared on HIT entry; the bit accepted here is the first fresh one.
                    state_nxt = FILL;
                    fill_nxt  = en ? FILL_ONE : '0;
                end
            end
            default: begin
                state_nxt = FILL;
                fill_nxt  = '0;
            end
        endcase
        if (match) begin
            state_nxt = HIT;
            fill_nxt  = overlap ? FILL_MAX : '0;
        end
    end

    // Moore output: high exactly while in HIT.
    assign Z = (state == HIT);

`ifdef SEQDET_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating count of HIT entries; clear beats a coincident match.
    always_ff @(posedge clk) begin
        if (!reset) begin
            match_count <= '0;
        end else if (count_clr) begin
            match_count <= '0;
        end else if (match && (match_count != CNT_MAX)) begin
            match_count <= match_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: doc/seq_detect.md
SEQ_DETECT -- requirements
Module: seq_detect

Interface
REQ-001 Parameter N, default 4, pattern length in bits, legal range 2..16.
REQ-002 Parameter PATTERN, default 4'b1011 (N bits wide), pattern to detect; MSB is the oldest bit.
REQ-003 Parameter CNT_W, default 8, match counter width (used only with SEQDET_COUNT_EN).
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 reset  in  1  synchronous, active-low reset; sampled on posedge clk only.
REQ-006 en  in  1  W-valid qualifier; a bit is accepted on a posedge where en=1.
REQ-007 W  in  1  serial data bit.
REQ-008 overlap  in  1  1 = overlapping detection, 0 = non-overlapping; sampled with each accepted bit.
REQ-009 Z  out  1  registered match pulse, Moore output of state HIT.
REQ-010 count_clr  in  1  synchronous counter clear (present only with SEQDET_COUNT_EN).
REQ-011 match_count  out  CNT_W  saturating match count (present only with SEQDET_COUNT_EN).

Function
REQ-012 The history register hist[N-1:0] SHALL shift on each accepted bit: hist <= {hist[N-2:0], W}; it holds when en=0.
REQ-013 The fill counter SHALL count accepted bits since reset or since the last non-overlapping match, saturating at N.
REQ-014 A match SHALL be the condition: accepted bit, fill+1 >= N, and {hist[N-2:0], W} == PATTERN; stale bits from before reset or before a non-overlap clear SHALL never match.
REQ-015 The FSM SHALL have three states, FILL (fill<N), ARMED (fill==N), HIT; Z = (state==HIT).
REQ-016 FILL: match -> HIT; accepted bit making fill==N without a match -> ARMED; otherwise stay in FILL.
REQ-017 ARMED: match -> HIT; otherwise stay in ARMED.
REQ-018 HIT, overlap=1 at match: fill stays N; next accepted bit that matches -> HIT, otherwise -> ARMED (including en=0).
REQ-019 HIT, overlap=0 at match: fill cleared to 0 at the HIT-entry edge; next state FILL, with fill=1 if a bit is accepted in HIT and 0 otherwise.
REQ-020 Latency: Z SHALL rise on the clk edge that accepts the completing bit and stay high exactly one cycle per match; back-to-back matches keep Z high on consecutive cycles.
REQ-021 Z SHALL be 0 in any cycle following a cycle with en=0.

Reset
REQ-022 With reset=0 at posedge clk: state=FILL, fill=0, hist=0, Z=0, match_count=0; reset overrides en, W and count_clr.
REQ-023 Reset mid-pattern SHALL discard all partial progress; N fresh accepted bits are required before the next match.

Configuration
REQ-024 Macro SEQDET_COUNT_EN defined: count_clr/match_count exist; match_count increments on every HIT entry, saturates at 2^CNT_W-1, and is cleared by count_clr=1; a clear coincident with a match yields 0.
REQ-025 Macro SEQDET_COUNT_EN undefined: no counter logic and no count_clr/match_count ports; all other behaviour is identical.

Verification (N=4, PATTERN=4'b1011 unless stated)
REQ-026 Reset, en=1, W=1,0,1,1 -> Z=1 for exactly the one cycle after the 4th bit edge, 0 otherwise.
REQ-027 overlap=1, W=1,0,1,1,0,1,1 -> Z pulses after bits 4 and 7; overlap=0 with the same stream -> pulse after bit 4 only.
REQ-028 W=1,0, then en=0 for 3 cycles with W toggling, then en=1 with W=1,1 -> single Z pulse after the last bit; Z=0 during the gap.
REQ-029 Accept bits 1,0,1, pulse reset=0 for one edge, then W=1 -> no Z; PATTERN=4'b0000 after reset with W=0 x3 -> no Z, 4th 0 -> Z.
REQ-030 SEQDET_COUNT_EN, CNT_W=2, overlap=1, W=1,0,1,1,0,1,1,0,1,1,0,1,1,0,1,1 -> 5 matches, match_count=3 (saturated); count_clr=1 on a match edge -> match_count=0.
